// File: rtl/fp_pkg.sv
// Shared double-precision constants, arbiter FSM encoding and IEEE-754 classification helpers.
package fp_pkg;

  localparam int unsigned FP_W   = 64;
  localparam int unsigned EXP_W  = 11;
  localparam int unsigned FRAC_W = 52;

  localparam logic [FP_W-1:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  function automatic logic is_nan(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '1) && (x[FRAC_W-1:0] != '0);
  endfunction

  function automatic logic is_inf(input logic [FP_W-1:0] x);
    return (x[FP_W-2 -: EXP_W] == '1) && (x[FRAC_W-1:0] == '0);
  endfunction

  function automatic logic is_zero(input logic [FP_W-1:0] x);
    return x[FP_W-2:0] == '0;
  endfunction

endpackage

// File: rtl/fp_sub.sv
// Combinational IEEE-754 double subtractor, round-to-nearest-even, full denormal support.
module fp_sub
  import fp_pkg::*;
(
  input  logic [FP_W-1:0] a,
  input  logic [FP_W-1:0] b,
  output logic [FP_W-1:0] result
);

  logic              sa, sb, sx, sy, swap;
  logic [EXP_W-1:0]  ex_f, ey_f;
  logic [FRAC_W-1:0] fx, fy;
  logic [11:0]       ex, ey, d, e_n;
  logic [52:0]       mx, my;
  logic [55:0]       my_ext, my_sh, n;
  logic              sticky;
  logic [56:0]       sum;
  logic [5:0]        lz, shamt;
  logic [62:0]       packed_v, rounded;
  logic              rnd, ovf;
  logic [FP_W-1:0]   finite_res;

  function automatic logic [5:0] lzc(input logic [55:0] v);
    logic [5:0] cnt;
    cnt = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (v[i]) cnt = 6'(55 - i);
    end
    return cnt;
  endfunction

  always_comb begin
    // a - b is evaluated as a + (-b); the larger magnitude goes in x
    sa   = a[63];
    sb   = ~b[63];
    swap = b[62:0] > a[62:0];
    sx   = swap ? sb : sa;
    sy   = swap ? sa : sb;
    ex_f = swap ? b[62:52] : a[62:52];
    ey_f = swap ? a[62:52] : b[62:52];
    fx   = swap ? b[51:0] : a[51:0];
    fy   = swap ? a[51:0] : b[51:0];

    ex = (ex_f == '0) ? 12'd1 : {1'b0, ex_f};
    ey = (ey_f == '0) ? 12'd1 : {1'b0, ey_f};
    mx = {(ex_f != '0), fx};
    my = {(ey_f != '0), fy};
    d  = ex - ey;

    my_ext = {my, 3'b000};
    if (d >= 12'd56) begin
      my_sh  = '0;
      sticky = |my;
    end else begin
      my_sh  = my_ext >> d;
      sticky = |(my_ext & ~({56{1'b1}} << d));
    end
    my_sh[0] = my_sh[0] | sticky;

    if (sx == sy) sum = {1'b0, mx, 3'b000} + {1'b0, my_sh};
    else          sum = {1'b0, mx, 3'b000} - {1'b0, my_sh};

    lz    = lzc(sum[55:0]);
    shamt = '0;
    if (sum[56]) begin
      n   = {sum[56:2], sum[1] | sum[0]};
      e_n = ex + 12'd1;
    end else if ({6'b0, lz} < ex) begin
      shamt = lz;
      n     = sum[55:0] << shamt;
      e_n   = ex - {6'b0, lz};
    end else begin
      // Underflow into the denormal range: stop at the minimum exponent
      shamt = 6'(ex - 12'd1);
      n     = sum[55:0] << shamt;
      e_n   = 12'd1;
    end

    ovf      = e_n >= 12'd2047;
    packed_v = {(n[55] ? e_n[10:0] : 11'd0), n[54:3]};
    rnd      = n[2] & (n[1] | n[0] | n[3]);
    // A carry out of the fraction bumps the exponent, including denormal -> normal
    rounded  = packed_v + {62'd0, rnd};

    if (sum == '0)  finite_res = {sx & sy, 63'd0};
    else if (ovf)   finite_res = {sx, 11'h7FF, 52'd0};
    else            finite_res = {sx, rounded};

    if (is_nan(a))                                   result = a | 64'h0008_0000_0000_0000;
    else if (is_nan(b))                              result = b | 64'h0008_0000_0000_0000;
    else if (is_inf(a) && is_inf(b) && a[63] == b[63]) result = QNAN;
    else if (is_inf(a))                              result = a;
    else if (is_inf(b))                              result = {~b[63], b[62:0]};
    else                                             result = finite_res;
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  logic        found;
  int unsigned j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = (32'(ptr) + k) % NUM_REQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/fp_sub_arbiter.sv
// Round-robin sharing of one fp_sub among NUM_REQ requesters; operands and result registered.
module fp_sub_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*64-1:0] req_a,
  input  logic [NUM_REQ*64-1:0] req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [63:0]           resp_result,
  output logic [ID_W-1:0]       resp_id,
  output logic                  resp_nan,
  output logic                  resp_inf,
  output logic                  resp_zero,
  output logic                  busy
);

  state_e              state_q;
  logic [ID_W-1:0]     ptr_q, id_q, resp_id_q, gnt_idx;
  logic [63:0]         op_a_q, op_b_q, result_q, sub_result;
  logic                resp_valid_q, busy_q, arb_en;
  logic [NUM_REQ-1:0]  gnt;

  // Gate with rst_n so no requester sees an acceptance that reset would discard
  assign arb_en = rst_n && (state_q == StIdle);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr_arbiter (
    .req  (req_valid),
    .ptr  (ptr_q),
    .en   (arb_en),
    .grant(gnt),
    .idx  (gnt_idx)
  );

  fp_sub u_fp_sub (
    .a     (op_a_q),
    .b     (op_b_q),
    .result(sub_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      result_q     <= '0;
      resp_id_q    <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|gnt) begin
            op_a_q  <= req_a[{gnt_idx, 6'b0} +: 64];
            op_b_q  <= req_b[{gnt_idx, 6'b0} +: 64];
            id_q    <= gnt_idx;
            ptr_q   <= (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
            state_q <= StExec;
            busy_q  <= 1'b1;
          end
        end
        StExec: begin
          result_q     <= sub_result;
          resp_id_q    <= id_q;
          resp_valid_q <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: begin
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign req_ready   = gnt;
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_id     = resp_id_q;
  assign busy        = busy_q;
  assign resp_nan    = is_nan(result_q);
  assign resp_inf    = is_inf(result_q);
  assign resp_zero   = is_zero(result_q);

endmodule
